// File: rtl/io_uart.sv
// io_uart: byte-wide memory-mapped UART (8N1) with a small TX FIFO and an RX
// holding register.
// Optional feature macro: IO_UART_IRQ_EN. When it is defined, the IE register
// and a registered level irq are present; otherwise IE reads 0 and irq is 0.
module io_uart #(
  parameter int          TX_DEPTH  = 2,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_write,
  input  logic       reg_read,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  localparam int          AW      = $clog2(TX_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // register bus decode
  logic wr_data, wr_status, wr_div_lo, wr_div_hi, rd_data;
  assign wr_data   = reg_write && (reg_addr == 4'd0);
  assign wr_status = reg_write && (reg_addr == 4'd1);
  assign wr_div_lo = reg_write && (reg_addr == 4'd2);
  assign wr_div_hi = reg_write && (reg_addr == 4'd3);
  assign rd_data   = reg_read  && (reg_addr == 4'd0);

  logic [15:0] div_q, div_d;

  // TX FIFO: extra pointer bit distinguishes full from empty
  logic [7:0]  fifo_q [TX_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, tx_push, tx_pop;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign tx_push    = wr_data && !fifo_full;

  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;
  logic        tx_idle;
  assign tx_idle = fifo_empty && (tx_state_q == S_IDLE);
  assign txd     = txd_q;

  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (tx_push) fifo_q[wptr_q[AW-1:0]] <= reg_wdata;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= DIV_RESET;
      wptr_q      <= '0;
      rptr_q      <= '0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      txd_q       <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      div_q       <= div_d;
      if (tx_push) wptr_q <= wptr_q + PTR_ONE;
      if (tx_pop)  rptr_q <= rptr_q + PTR_ONE;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_s1_q     <= rxd;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
    end
  end

  // divisor register; the counters pick up a new value on their next reload
  always_comb begin
    div_d = div_q;
    if (wr_div_lo) div_d[7:0]  = reg_wdata;
    if (wr_div_hi) div_d[15:8] = reg_wdata;
  end

  // TX FSM: START/DATA/STOP each last DIV+1 cycles; STOP chains into START if more data
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_q[rptr_q[AW-1:0]];
          txd_d      = 1'b0;
          tx_cnt_d   = div_q;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          txd_d      = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
          tx_bit_d   = 3'd0;
          tx_cnt_d   = div_q;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_q;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = fifo_q[rptr_q[AW-1:0]];
            txd_d      = 1'b0;
            tx_cnt_d   = div_q;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // RX FSM plus holding register/status; a same-cycle DATA read frees the slot
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (rd_data) rx_valid_d = 1'b0;
    if (wr_status && reg_wdata[3]) overrun_d   = 1'b0;
    if (wr_status && reg_wdata[4]) frame_err_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = div_q >> 1;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_q || rd_data) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

`ifdef IO_UART_IRQ_EN
  logic [1:0] ie_q;
  logic       irq_q;

  // interrupt enable register and registered level interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (reg_write && (reg_addr == 4'd4)) ie_q <= reg_wdata[1:0];
      irq_q <= (ie_q[0] & rx_valid_q) | (ie_q[1] & tx_idle);
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // combinational read mux; unmapped addresses read 0
  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      4'd0: reg_rdata = rx_data_q;
      4'd1: reg_rdata = {3'b000, frame_err_q, overrun_q, tx_idle, fifo_full, rx_valid_q};
      4'd2: reg_rdata = div_q[7:0];
      4'd3: reg_rdata = div_q[15:8];
`ifdef IO_UART_IRQ_EN
      4'd4: reg_rdata = {6'b000000, ie_q};
`endif
      default: reg_rdata = 8'h00;
    endcase
  end

endmodule
